imem_loadable: RTL and testbench

Parametrised instruction memory for the RISC-V core with a sequential program-load port, an automatic post-reset fill, and a registered fetch port with fault reporting. Sits between the program loader (testbench or boot logic) and the IF stage. Fetch uses a 1-cycle req/valid handshake. Misaligned and out-of-range fetches return a NOP and raise a fault flag.

---
 rtl/imem_loadable.sv | 137 +++++++++++++
 tb/tb_imem_loadable.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Loadable instruction memory. It fills itself with NOPs after reset, accepts sequential
// program loads, and serves registered fetches with fault reporting for misaligned or
// out-of-range addresses.
module imem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic                      load_valid,
  input  logic [DATA_W-1:0]         load_data,
  output logic                      load_ready,
  output logic [$clog2(DEPTH):0]    load_count,
  output logic                      load_full,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [DATA_W-1:0]         instr_out,
  output logic                      fetch_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_LOAD} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_load_count;
  logic                r_load_full;
  logic                r_load_ready;
  logic                r_fetch_ready;
  logic                r_fetch_valid;
  logic [DATA_W-1:0]   r_instr_out;
  logic                r_fetch_fault;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_misaligned;
  logic                w_out_of_range;
  logic [IDX_W-1:0]    w_index;
  logic                w_accept;
  logic                w_load_wr;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;

  assign w_misaligned   = |fetch_addr[1:0];
  assign w_out_of_range = |fetch_addr[ADDR_W-1:IDX_W+2];
  assign w_index        = fetch_addr[IDX_W+1:2];
  assign w_accept       = fetch_req & r_fetch_ready;
  assign w_load_wr      = (r_state == S_LOAD) & load_valid & r_load_ready;
  // The post-reset fill and program loads share one write port, addressed by r_ptr.
  assign w_we           = (r_state == S_INIT) | w_load_wr;
  assign w_wdata        = (r_state == S_INIT) ? NOP_WORD : load_data;

  // NOTE: the storage array has no reset. Clearing it is the job of the INIT fill, which
  // lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr] <= w_wdata;
  end

  // NOTE: all state and output registers use non-blocking assignments, so every register
  // in this block updates from the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_ptr         <= '0;
      r_load_count  <= '0;
      r_load_full   <= 1'b0;
      r_load_ready  <= 1'b0;
      r_fetch_ready <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_instr_out   <= '0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_fetch_valid <= w_accept;
      if (w_accept) begin
        if (w_misaligned || w_out_of_range) begin
          r_instr_out   <= NOP_WORD;
          r_fetch_fault <= 1'b1;
        end else begin
          r_instr_out   <= r_mem[w_index];
          r_fetch_fault <= 1'b0;
        end
      end

      case (r_state)
        S_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == IDX_W'(DEPTH - 1)) begin
            r_state       <= S_RUN;
            r_fetch_ready <= 1'b1;
          end
        end
        S_RUN: begin
          // A fetch request in the same cycle wins, so load entry waits for a quiet cycle.
          if (load_en && !fetch_req) begin
            r_state       <= S_LOAD;
            r_fetch_ready <= 1'b0;
            r_ptr         <= '0;
            r_load_count  <= '0;
            r_load_full   <= 1'b0;
            r_load_ready  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_load_wr) begin
            r_ptr        <= r_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
            if (r_load_count == CNT_W'(DEPTH - 1)) begin
              r_load_full  <= 1'b1;
              r_load_ready <= 1'b0;
            end
          end
          if (!load_en) begin
            r_state       <= S_RUN;
            r_fetch_ready <= 1'b1;
            r_load_ready  <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign load_ready  = r_load_ready;
  assign load_count  = r_load_count;
  assign load_full   = r_load_full;
  assign fetch_ready = r_fetch_ready;
  assign fetch_valid = r_fetch_valid;
  assign instr_out   = r_instr_out;
  assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed and randomized bench for imem_loadable. It checks against an array model of
// the memory contents and of the load-session rules.
module tb_imem_loadable;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en, load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [6:0]        load_count;
  logic              load_full;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready, fetch_valid, fetch_fault;
  logic [DATA_W-1:0] instr_out;

  imem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_count(load_count), .load_full(load_full),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .instr_out(instr_out), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  int          model_count;
  logic [31:0] load_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    model_count = 0;
  endtask

  // Expected {fault, word} for a byte address.
  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    if (a % 4 != 0 || a >= DEPTH * 4) return {1'b1, NOP};
    return {1'b0, model_mem[a / 4]};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_load_ready"},  load_ready,  0);
    check({tag, "_load_count"},  load_count,  0);
    check({tag, "_load_full"},   load_full,   0);
    check({tag, "_fetch_ready"}, fetch_ready, 0);
    check({tag, "_fetch_valid"}, fetch_valid, 0);
    check({tag, "_instr_out"},   instr_out,   0);
    check({tag, "_fetch_fault"}, fetch_fault, 0);
  endtask

  task automatic wait_fill(input string tag);
    int cnt = 0;
    while (fetch_ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, cnt, DEPTH);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a);
    logic [32:0] exp;
    exp        = model_fetch(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    check({tag, "_valid"}, fetch_valid, 1);
    check({tag, "_instr"}, instr_out, exp[31:0]);
    check({tag, "_fault"}, fetch_fault, exp[32]);
    tick();
    check({tag, "_pulse"}, fetch_valid, 0);
  endtask

  // Plays every word in load_q as a load beat, then leaves load mode.
  task automatic load_session(input string tag);
    load_en = 1'b1;
    tick();
    model_count = 0;
    check({tag, "_enter_fready"}, fetch_ready, 0);
    foreach (load_q[i]) begin
      check({tag, "_ready"}, load_ready, (model_count < DEPTH));
      load_valid = 1'b1;
      load_data  = load_q[i];
      tick();
      if (model_count < DEPTH) begin
        model_mem[model_count] = load_q[i];
        model_count++;
      end
    end
    load_valid = 1'b0;
    check({tag, "_count"},    load_count, model_count);
    check({tag, "_full"},     load_full,  (model_count == DEPTH));
    check({tag, "_ready_end"}, load_ready, (model_count < DEPTH));
    load_en = 1'b0;
    tick();
    check({tag, "_exit_fready"}, fetch_ready, 1);
    check({tag, "_exit_lready"}, load_ready, 0);
    check({tag, "_hold_count"},  load_count, model_count);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp;
    logic [31:0] a;
    reset = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    reset = 1'b0;
    wait_fill("fill_cycles");
    do_fetch("init_0x00", 32'h00);
    do_fetch("init_0xFC", 32'hFC);

    load_q = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};
    load_session("load4");
    do_fetch("prog_0x0", 32'h0);
    do_fetch("prog_0x4", 32'h4);
    do_fetch("prog_0x8", 32'h8);
    do_fetch("prog_0xC", 32'hC);
    do_fetch("prog_0x10", 32'h10);

    do_fetch("fault_mis", 32'h02);
    do_fetch("fault_oor", 32'h100);
    do_fetch("edge_0xFC", 32'hFC);

    load_q = {};
    for (int i = 0; i < DEPTH + 3; i++) load_q.push_back(32'(i));
    load_session("loadfull");
    do_fetch("full_w0", 32'h0);
    do_fetch("full_w63", 32'hFC);

    // Held request stream with load_en raised alongside it.
    fetch_req = 1'b1;
    load_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      exp = model_fetch(fetch_addr);
      tick();
      check("b2b_valid", fetch_valid, 1);
      check("b2b_instr", instr_out, exp[31:0]);
      check("b2b_fault", fetch_fault, exp[32]);
    end
    check("defer_fready", fetch_ready, 1);
    fetch_req = 1'b0;
    tick();
    model_count = 0;
    check("defer_valid_drop", fetch_valid, 0);
    check("defer_enter_fready", fetch_ready, 0);
    check("defer_enter_lready", load_ready, 1);
    check("defer_count_clear", load_count, 0);
    check("defer_full_clear", load_full, 0);
    load_en = 1'b0;
    tick();
    check("defer_exit_fready", fetch_ready, 1);

    for (int r = 0; r < 2; r++) begin
      load_q = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) load_q.push_back($urandom);
      load_session("rand_load");
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
          2:       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
          default: a = $urandom | 32'h100;
        endcase
        do_fetch("rand_fetch", a);
      end
    end

    // Abort a load session after its 10th word.
    load_q = {};
    for (int i = 0; i < 10; i++) load_q.push_back(32'hA000_0000 + 32'(i));
    load_en = 1'b1;
    tick();
    foreach (load_q[i]) begin
      load_valid = 1'b1;
      load_data  = load_q[i];
      tick();
    end
    check("abort_pre_count", load_count, 10);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    load_en = 1'b0; load_valid = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    wait_fill("refill_cycles");
    do_fetch("refill_0x0", 32'h0);
    do_fetch("refill_0x24", 32'h24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
